// File: rtl/dm_resp_pkg.sv
// Shared types and constants for the data-memory responder.
// The FSM encoding is a plain vector so it stays compatible with older tooling.
package dm_resp_pkg;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int WAIT_CNT_W     = 4;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE   = 2'd0;
  localparam state_t ST_WAIT   = 2'd1;
  localparam state_t ST_ACCESS = 2'd2;
  localparam state_t ST_RESP   = 2'd3;

  function automatic logic is_store(input logic [BYTES_PER_WORD-1:0] w_en);
    return |w_en;
  endfunction

endpackage

// File: rtl/byte_en_ram.sv
// Single-port synchronous word array with per-byte write enables.
// Read data is registered (read-before-write) and is not reset.
module byte_en_ram
  import dm_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int IDX_W       = 12
) (
  input  logic                      clk,
  input  logic [IDX_W-1:0]          addr,
  input  logic [BYTES_PER_WORD-1:0] we,
  input  logic [WORD_W-1:0]         wdata,
  output logic [WORD_W-1:0]         rdata
);

  logic [WORD_W-1:0] mem_r [DEPTH_WORDS];
  logic [WORD_W-1:0] rdata_r;

  // Byte-lane writes and registered read of the addressed word
  always_ff @(posedge clk) begin
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (we[i]) begin
        mem_r[addr][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
    rdata_r <= mem_r[addr];
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/dm_responder.sv
// Multi-cycle valid/ready responder for the CPU data-memory port.
// One request outstanding; WAIT_CYCLES wait states precede the array access.
module dm_responder
  import dm_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_w_en,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [WAIT_CNT_W-1:0] CNT_INIT =
    (WAIT_CYCLES == 0) ? {WAIT_CNT_W{1'b0}} : WAIT_CNT_W'(WAIT_CYCLES - 1);

  state_t                    state_r;
  logic [WAIT_CNT_W-1:0]     cnt_r;
  logic [IDX_W-1:0]          addr_idx_r;
  logic [BYTES_PER_WORD-1:0] w_en_r;
  logic [WORD_W-1:0]         wdata_r;
  logic                      err_r;
  logic                      req_ready_r;
  logic                      resp_valid_r;
  logic [WORD_W-1:0]         resp_rdata_r;
  logic                      resp_err_r;

  logic                      req_in_range_s;
  logic [IDX_W-1:0]          ram_addr_s;
  logic [BYTES_PER_WORD-1:0] ram_we_s;
  logic [WORD_W-1:0]         ram_rdata_s;
  logic                      unused_addr_lsb_s;

  // Full index compared, so out-of-range addresses never alias onto low words
  assign req_in_range_s    = ({2'b00, req_addr[31:2]} < 32'(DEPTH_WORDS));
  assign unused_addr_lsb_s = ^req_addr[1:0];

  // The read is issued one cycle before ACCESS (from the live request when
  // WAIT_CYCLES is 0) so the registered RAM output is ready inside ACCESS.
  always_comb begin
    ram_addr_s = addr_idx_r;
    ram_we_s   = 4'b0000;
    if (state_r == ST_IDLE) begin
      ram_addr_s = req_addr[IDX_W+1:2];
    end else if ((state_r == ST_ACCESS) && !err_r) begin
      ram_we_s = w_en_r;
    end else begin
      ram_we_s = 4'b0000;
    end
  end

  byte_en_ram #(
    .DEPTH_WORDS(DEPTH_WORDS),
    .IDX_W      (IDX_W)
  ) u_ram (
    .clk  (clk),
    .addr (ram_addr_s),
    .we   (ram_we_s),
    .wdata(wdata_r),
    .rdata(ram_rdata_s)
  );

  // Request/response FSM with registered handshake outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= {WAIT_CNT_W{1'b0}};
      addr_idx_r   <= {IDX_W{1'b0}};
      w_en_r       <= 4'b0000;
      wdata_r      <= 32'h0000_0000;
      err_r        <= 1'b0;
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_rdata_r <= 32'h0000_0000;
      resp_err_r   <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (!req_ready_r) begin
            req_ready_r <= 1'b1;
          end else if (req_valid) begin
            addr_idx_r  <= req_addr[IDX_W+1:2];
            w_en_r      <= req_w_en;
            wdata_r     <= req_wdata;
            err_r       <= !req_in_range_s;
            req_ready_r <= 1'b0;
            cnt_r       <= CNT_INIT;
            state_r     <= (WAIT_CYCLES == 0) ? ST_ACCESS : ST_WAIT;
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (cnt_r == {WAIT_CNT_W{1'b0}}) begin
            state_r <= ST_ACCESS;
          end else begin
            cnt_r <= cnt_r - {{(WAIT_CNT_W-1){1'b0}}, 1'b1};
          end
        end
        ST_ACCESS: begin
          resp_valid_r <= 1'b1;
          resp_err_r   <= err_r;
          resp_rdata_r <= (err_r || is_store(w_en_r)) ? 32'h0000_0000 : ram_rdata_s;
          state_r      <= ST_RESP;
        end
        ST_RESP: begin
          if (resp_ready) begin
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            req_ready_r  <= 1'b1;
            state_r      <= ST_IDLE;
          end else begin
            state_r <= ST_RESP;
          end
        end
        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_rdata = resp_rdata_r;
  assign resp_err   = resp_err_r;

endmodule

// File: tb/tb_dm_responder.sv
// Directed scoreboard bench for dm_responder: a WAIT_CYCLES=2 instance (a_*)
// and a WAIT_CYCLES=0 instance (b_*) sharing clock and reset.
module tb_dm_responder;

  localparam int DEPTH_A = 4096;
  localparam int DEPTH_B = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        req_valid, req_ready, resp_valid, resp_ready, resp_err;
  logic [31:0] req_addr, req_wdata, resp_rdata;
  logic [3:0]  req_w_en;
  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_ready, b_resp_err;
  logic [31:0] b_req_addr, b_req_wdata, b_resp_rdata;
  logic [3:0]  b_req_w_en;

  dm_responder #(.DEPTH_WORDS(DEPTH_A), .WAIT_CYCLES(2)) u_dut_a (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_w_en(req_w_en), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .resp_err(resp_err)
  );

  dm_responder #(.DEPTH_WORDS(DEPTH_B), .WAIT_CYCLES(0)) u_dut_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_addr(b_req_addr),
    .req_w_en(b_req_w_en), .req_wdata(b_req_wdata),
    .resp_valid(b_resp_valid), .resp_ready(b_resp_ready),
    .resp_rdata(b_resp_rdata), .resp_err(b_resp_err)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int acc_cyc = 0;
  logic [32:0] exp_q[$];
  logic [31:0] ref_mem[int];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference model for instance A: returns {err, rdata} and applies stores.
  function automatic logic [32:0] model(input logic [31:0] addr, input logic [3:0] we,
                                        input logic [31:0] wd);
    logic [31:0] w;
    int idx;
    if ({2'b00, addr[31:2]} >= 32'(DEPTH_A)) return {1'b1, 32'h0};
    idx = int'(addr[31:2]);
    w = ref_mem.exists(idx) ? ref_mem[idx] : 32'h0;
    if (we != 4'b0000) begin
      for (int b = 0; b < 4; b++) if (we[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[idx] = w;
      return {1'b0, 32'h0};
    end
    return {1'b0, w};
  endfunction

  task automatic issue(input logic [31:0] addr, input logic [3:0] we, input logic [31:0] wd);
    int n = 0;
    req_valid = 1'b1; req_addr = addr; req_w_en = we; req_wdata = wd;
    while (req_ready !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    check("a_req_ready_before_accept", 64'(req_ready), 64'd1);
    if (req_ready === 1'b1) begin
      @(posedge clk); #1;
      acc_cyc = cyc;
      exp_q.push_back(model(addr, we, wd));
    end
    req_valid = 1'b0;
  endtask

  task automatic collect(input int lat, input int hold);
    int n = 0;
    logic [32:0] e;
    logic [31:0] rd;
    logic er;
    while (resp_valid !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    check("a_resp_valid", 64'(resp_valid), 64'd1);
    check("a_latency", 64'(cyc - acc_cyc), 64'(lat));
    check("a_scoreboard_depth", 64'(exp_q.size()), 64'd1);
    e = (exp_q.size() > 0) ? exp_q.pop_front() : {1'b1, 32'hFFFF_FFFF};
    check("a_resp_rdata", 64'(resp_rdata), 64'(e[31:0]));
    check("a_resp_err", 64'(resp_err), 64'(e[32]));
    check("a_req_ready_in_resp", 64'(req_ready), 64'd0);
    rd = resp_rdata; er = resp_err;
    repeat (hold) begin
      @(posedge clk); #1;
      check("a_hold_valid", 64'(resp_valid), 64'd1);
      check("a_hold_rdata", 64'(resp_rdata), 64'(rd));
      check("a_hold_err", 64'(resp_err), 64'(er));
      check("a_hold_req_ready", 64'(req_ready), 64'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check("a_after_hs_valid", 64'(resp_valid), 64'd0);
    check("a_after_hs_err", 64'(resp_err), 64'd0);
    check("a_after_hs_req_ready", 64'(req_ready), 64'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_a_req_ready"}, 64'(req_ready), 64'd0);
    check({tag, "_a_resp_valid"}, 64'(resp_valid), 64'd0);
    check({tag, "_a_resp_rdata"}, 64'(resp_rdata), 64'd0);
    check({tag, "_a_resp_err"}, 64'(resp_err), 64'd0);
    check({tag, "_b_req_ready"}, 64'(b_req_ready), 64'd0);
    check({tag, "_b_resp_valid"}, 64'(b_resp_valid), 64'd0);
  endtask

  logic [31:0] b_addr_t[7];
  logic [31:0] b_wd_t[7];
  logic [3:0]  b_we_t[7];
  logic [32:0] b_exp_t[7];
  logic [31:0] saved_word;
  int b_acc, b_prev, n;

  initial begin
    rst = 1'b0;
    req_valid = 1'b0; req_addr = 32'h0; req_w_en = 4'h0; req_wdata = 32'h0; resp_ready = 1'b0;
    b_req_valid = 1'b0; b_req_addr = 32'h0; b_req_w_en = 4'h0; b_req_wdata = 32'h0;
    b_resp_ready = 1'b0;

    // Reset state and release timing
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst");
    rst = 1'b1;
    #1;
    check("rel_a_req_ready_pre_edge", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("rel_a_req_ready", 64'(req_ready), 64'd1);
    check("rel_b_req_ready", 64'(b_req_ready), 64'd1);

    // Full store then load; resp_ready held early has no effect before valid
    issue(32'h0000_0010, 4'b1111, 32'hDEAD_BEEF);
    collect(3, 0);
    resp_ready = 1'b1;
    issue(32'h0000_0010, 4'b0000, 32'h0);
    collect(3, 0);

    // Byte-lane merge on one word
    issue(32'h0000_0040, 4'b1111, 32'h1122_3344);
    collect(3, 0);
    issue(32'h0000_0041, 4'b0001, 32'h0000_00AA);
    collect(3, 0);
    issue(32'h0000_0043, 4'b1000, 32'hBB00_0000);
    collect(3, 0);
    issue(32'h0000_0040, 4'b0000, 32'h0);
    collect(3, 0);

    // Backpressure with a competing request held valid during RESP
    issue(32'h0000_0080, 4'b1111, 32'hCAFE_F00D);
    collect(3, 0);
    issue(32'h0000_0080, 4'b0000, 32'h0);
    req_valid = 1'b1; req_addr = 32'h0000_0010; req_w_en = 4'b0000;
    collect(3, 5);
    issue(32'h0000_0010, 4'b0000, 32'h0);
    collect(3, 0);

    // Range boundaries and no wrap-around
    issue(32'(4 * (DEPTH_A - 1)), 4'b1111, 32'h7777_8888);
    collect(3, 0);
    issue(32'(4 * (DEPTH_A - 1)), 4'b0000, 32'h0);
    collect(3, 0);
    issue(32'h0000_0000, 4'b1111, 32'h0123_4567);
    collect(3, 0);
    issue(32'(4 * DEPTH_A), 4'b1111, 32'hFFFF_FFFF);
    collect(3, 0);
    issue(32'h8000_0000, 4'b1111, 32'hEEEE_EEEE);
    collect(3, 0);
    issue(32'(4 * DEPTH_A), 4'b0000, 32'h0);
    collect(3, 0);
    issue(32'h0000_0000, 4'b0000, 32'h0);
    collect(3, 0);

    // Reset during WAIT drops the store
    issue(32'h0000_0020, 4'b1111, 32'h5555_AAAA);
    collect(3, 0);
    saved_word = ref_mem[8];
    issue(32'h0000_0020, 4'b1111, 32'h1234_5678);
    rst = 1'b0;
    #1;
    check_reset_outputs("mid");
    repeat (4) @(posedge clk);
    #1;
    check_reset_outputs("mid_hold");
    ref_mem[8] = saved_word;
    exp_q.delete();
    rst = 1'b1;
    #1;
    check("mid_rel_req_ready_pre_edge", 64'(req_ready), 64'd0);
    @(posedge clk); #1;
    check("mid_rel_req_ready", 64'(req_ready), 64'd1);
    issue(32'h0000_0020, 4'b0000, 32'h0);
    collect(3, 0);

    // Zero-wait instance: back-to-back traffic, resp_ready held high
    for (int k = 0; k < 3; k++) begin
      b_addr_t[k] = 32'(4 * (k + 1)); b_we_t[k] = 4'b1111;
      b_wd_t[k] = 32'hA0A0_0000 + 32'(k); b_exp_t[k] = {1'b0, 32'h0};
      b_addr_t[k+3] = 32'(4 * (k + 1)); b_we_t[k+3] = 4'b0000;
      b_wd_t[k+3] = 32'h0; b_exp_t[k+3] = {1'b0, 32'hA0A0_0000 + 32'(k)};
    end
    b_addr_t[6] = 32'(4 * DEPTH_B); b_we_t[6] = 4'b0000; b_wd_t[6] = 32'h0;
    b_exp_t[6] = {1'b1, 32'h0};
    b_resp_ready = 1'b1;
    b_req_valid = 1'b1;
    b_prev = 0;
    for (int k = 0; k < 7; k++) begin
      b_req_addr = b_addr_t[k]; b_req_w_en = b_we_t[k]; b_req_wdata = b_wd_t[k];
      n = 0;
      while (b_req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      check("b_req_ready", 64'(b_req_ready), 64'd1);
      @(posedge clk); #1;
      b_acc = cyc;
      if (k > 0) check("b_spacing", 64'(b_acc - b_prev), 64'd3);
      b_prev = b_acc;
      n = 0;
      while (b_resp_valid !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      check("b_resp_valid", 64'(b_resp_valid), 64'd1);
      check("b_latency", 64'(cyc - b_acc), 64'd1);
      check("b_resp_rdata", 64'(b_resp_rdata), 64'(b_exp_t[k][31:0]));
      check("b_resp_err", 64'(b_resp_err), 64'(b_exp_t[k][32]));
    end
    b_req_valid = 1'b0;
    @(posedge clk); #1;
    check("b_final_valid", 64'(b_resp_valid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
